// File: rtl/axis_spi_cmd_decoder_pkg.sv
// Shared definitions for the SPI command frame decoder: opcodes, FSM state encoding
// and sticky error bit positions.
package spi_cmd_pkg;

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_WDATA,
        ST_WXSUM,
        ST_RREQ,
        ST_RWAIT,
        ST_RSEND,
        ST_RXSUM
    } state_e;

    localparam int ERR_BAD_CMD = 0;
    localparam int ERR_BAD_LEN = 1;
    localparam int ERR_TIMEOUT = 2;

    // States where the host is expected to keep clocking bytes in.
    function automatic logic timed_state(input state_e s);
        return s inside {ST_ADDR, ST_LEN, ST_WDATA, ST_WXSUM};
    endfunction

endpackage

// File: rtl/axis_spi_cmd_decoder_if.sv
// Byte-wide AXI-Stream link between the SPI bridge and the command decoder.
interface axis_spi_cmd_decoder_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_spi_cmd_decoder_spi_idle_timer.sv
// Saturating idle counter: expire pulses on the TIMEOUT_CYCLES-th consecutive
// uncleared clock.
module spi_idle_timer #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic expire
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expire = !clr && (cnt_q == LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/axis_spi_cmd_decoder.sv
// Decodes [CMD][ADDR][LEN][data...] frames from the SPI bridge into register-bus
// writes/reads. Define SPI_CMD_XSUM_EN to append and check an XOR frame checksum.
module axis_spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17
) (
    input  logic                          axis_aclk,
    input  logic                          axis_aresetn,
    axis_spi_cmd_decoder_if.slave         s_axis,
    axis_spi_cmd_decoder_if.master        m_axis,
    output logic [7:0]                    reg_addr,
    output logic [7:0]                    reg_wdata,
    output logic                          reg_we,
    output logic                          reg_re,
    input  logic [7:0]                    reg_rdata,
    output logic                          busy,
    output logic [2:0]                    err
);
`ifdef SPI_CMD_XSUM_EN
    localparam state_e WR_END  = ST_WXSUM;
    localparam state_e RD_END  = ST_RXSUM;
    localparam bit     XSUM_EN = 1'b1;
`else
    localparam state_e WR_END  = ST_IDLE;
    localparam state_e RD_END  = ST_IDLE;
    localparam bit     XSUM_EN = 1'b0;
`endif

    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] len_q, len_d;
    logic [7:0] data_q, data_d;
    logic       is_rd_q, is_rd_d;
    logic [2:0] err_q, err_d;
    logic [7:0] xsum_val;
    logic       rx_ready, rx_fire, tx_valid, tx_fire, tmo_expire;

    assign rx_ready      = !(state_q inside {ST_RREQ, ST_RWAIT});
    assign s_axis.tready = rx_ready;
    assign rx_fire       = s_axis.tvalid && rx_ready;
    assign tx_valid      = state_q inside {ST_RSEND, ST_RXSUM};
    assign tx_fire       = tx_valid && m_axis.tready;

    spi_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_idle_timer (
        .clk    (axis_aclk),
        .rst_n  (axis_aresetn),
        .clr    (rx_fire || tx_fire || !timed_state(state_q)),
        .expire (tmo_expire)
    );

`ifdef SPI_CMD_XSUM_EN
    logic [7:0] xsum_q, xsum_d;

    // Running XOR over CMD, ADDR, LEN and every data byte in either direction.
    always_comb begin
        xsum_d = xsum_q;
        if (rx_fire && state_q == ST_IDLE) begin
            xsum_d = s_axis.tdata;
        end else if (rx_fire && state_q inside {ST_ADDR, ST_LEN, ST_WDATA}) begin
            xsum_d = xsum_q ^ s_axis.tdata;
        end else if (state_q == ST_RWAIT) begin
            xsum_d = xsum_q ^ reg_rdata;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            xsum_q <= '0;
        end else begin
            xsum_q <= xsum_d;
        end
    end

    assign xsum_val = xsum_q;
`else
    assign xsum_val = 8'h00;
`endif

    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            data_q  <= '0;
            is_rd_q <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            data_q  <= data_d;
            is_rd_q <= is_rd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        data_d  = data_q;
        is_rd_d = is_rd_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: if (rx_fire) begin
                if (s_axis.tdata == CMD_WR || s_axis.tdata == CMD_RD) begin
                    is_rd_d = (s_axis.tdata == CMD_RD);
                    state_d = ST_ADDR;
                end else begin
                    err_d[ERR_BAD_CMD] = 1'b1;
                end
            end
            ST_ADDR: if (rx_fire) begin
                addr_d  = s_axis.tdata;
                state_d = ST_LEN;
            end
            ST_LEN: if (rx_fire) begin
                if (s_axis.tdata == 8'h00) begin
                    err_d[ERR_BAD_LEN] = 1'b1;
                    state_d            = ST_IDLE;
                end else begin
                    len_d   = s_axis.tdata;
                    state_d = is_rd_q ? ST_RREQ : ST_WDATA;
                end
            end
            ST_WDATA: if (rx_fire) begin
                addr_d  = addr_q + 8'd1;
                len_d   = len_q - 8'd1;
                state_d = (len_q == 8'd1) ? WR_END : ST_WDATA;
            end
            ST_WXSUM: if (rx_fire) begin
                if (s_axis.tdata != xsum_val) err_d[ERR_BAD_LEN] = 1'b1;
                state_d = ST_IDLE;
            end
            ST_RREQ:  state_d = ST_RWAIT;
            ST_RWAIT: begin
                data_d  = reg_rdata;
                state_d = ST_RSEND;
            end
            ST_RSEND: if (tx_fire) begin
                addr_d  = addr_q + 8'd1;
                len_d   = len_q - 8'd1;
                state_d = (len_q == 8'd1) ? RD_END : ST_RREQ;
            end
            ST_RXSUM: if (tx_fire) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (tmo_expire) begin
            err_d[ERR_TIMEOUT] = 1'b1;
            state_d            = ST_IDLE;
        end
    end

    // Register strobes are combinational so a write lands in the same clock as its byte.
    always_comb begin
        m_axis.tvalid = tx_valid;
        m_axis.tdata  = 8'h00;
        m_axis.tlast  = 1'b0;
        reg_we        = 1'b0;
        reg_re        = 1'b0;
        reg_wdata     = 8'h00;
        reg_addr      = addr_q;
        busy          = (state_q != ST_IDLE);
        err           = err_q;
        unique case (state_q)
            ST_WDATA: begin
                reg_we    = rx_fire;
                reg_wdata = rx_fire ? s_axis.tdata : 8'h00;
            end
            ST_RREQ:  reg_re = 1'b1;
            ST_RSEND: begin
                m_axis.tdata = data_q;
                m_axis.tlast = (len_q == 8'd1) && !XSUM_EN;
            end
            ST_RXSUM: begin
                m_axis.tdata = xsum_val;
                m_axis.tlast = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_axis_spi_cmd_decoder.sv
// Self-checking bench for axis_spi_cmd_decoder: vector table, hand sequences for
// wrap/backpressure/timeout/reset, and random frames against a frame-level model.
module tb_axis_spi_cmd_decoder;
    import spi_cmd_pkg::*;

    localparam int TMO = 40;
    localparam int CW  = 6;
`ifdef SPI_CMD_XSUM_EN
    localparam bit XSUM = 1'b1;
`else
    localparam bit XSUM = 1'b0;
`endif

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    axis_spi_cmd_decoder_if rx();
    axis_spi_cmd_decoder_if tx();

    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_re, busy;
    logic [2:0] err;

    axis_spi_cmd_decoder #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
        .axis_aclk    (clk),
        .axis_aresetn (aresetn),
        .s_axis       (rx),
        .m_axis       (tx),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_we       (reg_we),
        .reg_re       (reg_re),
        .reg_rdata    (reg_rdata),
        .busy         (busy),
        .err          (err)
    );

    typedef struct packed {
        logic [5:0][7:0]  b;    // byte k is b[5-k]
        logic [2:0]       nb;
        logic [1:0]       nwr;
        logic [2:0][15:0] wr;   // write k is wr[2-k] = {addr, data}
        logic [2:0]       err;
    } vec_t;

    vec_t       tbl[5];
    int         n_checks = 0;
    int         n_errs = 0;
    int         stab_err = 0;
    int         ready_mode = 0;   // 0 always ready, 1 random, 2 stalled
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] mem[256];
    logic [7:0] exp_mem[256];
    logic [15:0] obs_wr[$], exp_wr[$];
    logic [8:0]  obs_tx[$], exp_tx[$];
    logic [2:0]  exp_err;

    // Register file: read data valid only in the clock after reg_re.
    always @(posedge clk) reg_rdata <= reg_re ? mem[reg_addr] : 8'($urandom);

    // Host side TX ready generation plus write/TX capture, sampled mid-cycle.
    always begin
        @(negedge clk);
        case (ready_mode)
            0:       tx.tready = 1'b1;
            1:       tx.tready = 1'($urandom_range(0, 1));
            default: tx.tready = 1'b0;
        endcase
        #2;
        if (aresetn) begin
            if (prev_stall && !(tx.tvalid && tx.tdata == prev_data)) stab_err++;
            if (tx.tvalid && tx.tready) obs_tx.push_back({tx.tlast, tx.tdata});
            if (reg_we) begin
                obs_wr.push_back({reg_addr, reg_wdata});
                mem[reg_addr] = reg_wdata;
            end
        end
        prev_stall = aresetn && tx.tvalid && !tx.tready;
        prev_data  = tx.tdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [47:0] b, input logic [2:0] nb,
                                 input logic [1:0] nwr, input logic [47:0] wr,
                                 input logic [2:0] e);
        vec_t v;
        v.b = b; v.nb = nb; v.nwr = nwr; v.wr = wr; v.err = e;
        return v;
    endfunction

    task automatic init_mems();
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            mem[i] = v;
            exp_mem[i] = v;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        aresetn = 1'b0;
        rx.tvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        obs_wr.delete(); exp_wr.delete(); obs_tx.delete(); exp_tx.delete();
        exp_err = 3'b000;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx.tdata = b;
        rx.tvalid = 1'b1;
        while (!rx.tready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("rx_accept_timeout", 32'(n), 0);
        @(posedge clk);
        #1;
        rx.tvalid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tx(input int n);
        int c = 0;
        while (obs_tx.size() < n && c < 3000) begin
            @(posedge clk);
            c++;
        end
        if (c >= 3000) check("tx_wait_timeout", obs_tx.size(), n);
    endtask

    task automatic wait_tvalid();
        int c = 0;
        @(negedge clk);
        while (!tx.tvalid && c < 50) begin
            @(negedge clk);
            c++;
        end
        #3;
        check("tvalid_rise", tx.tvalid, 1);
    endtask

    // Reference model: a write of d[] at a lands at a, a+1, ... modulo 256.
    task automatic model_write(input logic [7:0] a, input logic [7:0] d[$]);
        foreach (d[i]) begin
            exp_wr.push_back({8'(a + i), d[i]});
            exp_mem[8'(a + i)] = d[i];
        end
    endtask

    task automatic model_read(input logic [7:0] a, input int len);
        logic [7:0] x, v;
        x = CMD_RD ^ a ^ 8'(len);
        for (int i = 0; i < len; i++) begin
            v = exp_mem[8'(a + i)];
            x ^= v;
            exp_tx.push_back({(!XSUM && i == len - 1), v});
        end
        if (XSUM) exp_tx.push_back({1'b1, x});
    endtask

    task automatic do_write(input logic [7:0] a, input int len);
        logic [7:0] d[$];
        logic [7:0] f[$];
        logic [7:0] x;
        for (int i = 0; i < len; i++) d.push_back(8'($urandom));
        f.push_back(CMD_WR); f.push_back(a); f.push_back(8'(len));
        foreach (d[i]) f.push_back(d[i]);
        if (XSUM) begin
            x = 8'h00;
            foreach (f[i]) x ^= f[i];
            f.push_back(x);
        end
        model_write(a, d);
        send_bytes(f);
    endtask

    task automatic do_read(input logic [7:0] a, input int len);
        model_read(a, len);
        send_bytes('{CMD_RD, a, 8'(len)});
        wait_tx(exp_tx.size());
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_nwr"}, obs_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
            check({tag, "_wr"}, obs_wr[i], exp_wr[i]);
        check({tag, "_ntx"}, obs_tx.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++)
            check({tag, "_tx"}, obs_tx[i], exp_tx[i]);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_busy"}, busy, 0);
        obs_wr.delete(); exp_wr.delete(); obs_tx.delete(); exp_tx.delete();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int kind;
        logic [7:0] b;

        rx.tvalid = 1'b0; rx.tdata = 8'h00; rx.tlast = 1'b0;
        tbl[0] = mkv({8'h01, 8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC}, 3'd6, 2'd3, 48'h10AA_11BB_12CC, 3'b000);
        tbl[1] = mkv({8'h7F, 40'h0}, 3'd1, 2'd0, 48'h0, 3'b001);
        tbl[2] = mkv({8'h01, 8'h20, 8'h00, 24'h0}, 3'd3, 2'd0, 48'h0, 3'b010);
        tbl[3] = mkv({8'h7F, 8'h01, 8'hFF, 8'h02, 8'h12, 8'h34}, 3'd6, 2'd2, 48'hFF12_0034_0000, 3'b001);
        tbl[4] = mkv({8'h01, 8'h30, 8'h01, 8'h55, 16'h0}, 3'd4, 2'd1, 48'h3055_0000_0000, 3'b000);
        init_mems();
        do_reset();

        check("rst_s_tready", rx.tready, 1);
        check("rst_m_tvalid", tx.tvalid, 0);
        check("rst_m_tdata", tx.tdata, 0);
        check("rst_m_tlast", tx.tlast, 0);
        check("rst_strobes", {reg_we, reg_re}, 0);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_reg_wdata", reg_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);

`ifndef SPI_CMD_XSUM_EN
        for (int t = 0; t < 5; t++) begin
            do_reset();
            for (int k = 0; k < int'(tbl[t].nb); k++) send_byte(tbl[t].b[5 - k]);
            idle(4);
            check("tbl_nwr", obs_wr.size(), tbl[t].nwr);
            for (int k = 0; k < int'(tbl[t].nwr) && k < obs_wr.size(); k++)
                check("tbl_wr", obs_wr[k], tbl[t].wr[2 - k]);
            check("tbl_err", err, tbl[t].err);
            check("tbl_busy", busy, 0);
            obs_wr.delete();
        end
        init_mems();
`else
        do_reset();
        send_bytes('{8'h01, 8'h05, 8'h01, 8'h5A, 8'h5F});
        model_write(8'h05, '{8'h5A});
        idle(4);
        compare_all("xsum_ok");
        send_bytes('{8'h01, 8'h05, 8'h01, 8'h5A, 8'h00});
        model_write(8'h05, '{8'h5A});
        exp_err = 3'b010;
        idle(4);
        compare_all("xsum_bad");
`endif

        // Read across the address wrap with a 10-clock stall on the first byte.
        do_reset();
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
        exp_mem[8'hFE] = 8'h11; exp_mem[8'hFF] = 8'h22; exp_mem[8'h00] = 8'h33;
        stab_err = 0;
        ready_mode = 2;
        model_read(8'hFE, 3);
        send_bytes('{8'h02, 8'hFE, 8'h03});
        wait_tvalid();
        repeat (10) begin
            @(negedge clk);
            #3;
            check("bp_tdata", {tx.tvalid, tx.tdata}, 9'h111);
        end
        ready_mode = 0;
        wait_tx(exp_tx.size());
        idle(4);
        compare_all("rd_wrap");
        check("bp_stable", stab_err, 0);

        // Length-zero abort, then mid-frame timeout keeping the already issued write.
        do_reset();
        send_bytes('{8'h01, 8'h20, 8'h00});
        exp_err = 3'b010;
        idle(3);
        compare_all("len0");
        send_bytes('{8'h01, 8'h20, 8'h02, 8'hAA});
        model_write(8'h20, '{8'hAA});
        repeat (TMO - 1) @(posedge clk);
        #1;
        check("tmo_busy_before", busy, 1);
        check("tmo_err_before", err, 3'b010);
        @(posedge clk);
        #1;
        check("tmo_busy_after", busy, 0);
        exp_err = 3'b110;
        idle(2);
        compare_all("tmo");

        // Reset while a read byte is waiting on the host.
        do_reset();
        send_byte(8'h7F);
        idle(1);
        check("pre_rst_err", err, 3'b001);
        ready_mode = 2;
        send_bytes('{8'h02, 8'h40, 8'h02});
        wait_tvalid();
        check("pre_rst_busy", busy, 1);
        aresetn = 1'b0;
        @(posedge clk);
        #1;
        check("rst_rsend_tvalid", tx.tvalid, 0);
        check("rst_rsend_busy", busy, 0);
        check("rst_rsend_err", err, 0);
        check("rst_rsend_dropped", obs_tx.size(), 0);
        @(negedge clk);
        aresetn = 1'b1;
        ready_mode = 0;

        // Random frames with random host backpressure.
        do_reset();
        init_mems();
        stab_err = 0;
        ready_mode = 1;
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                do_write(8'($urandom), $urandom_range(1, 6));
            end else if (kind < 8) begin
                do_read(8'($urandom), $urandom_range(1, 4));
            end else if (kind == 8) begin
                do b = 8'($urandom); while (b == CMD_WR || b == CMD_RD);
                send_byte(b);
                exp_err[0] = 1'b1;
            end else begin
                send_bytes('{($urandom_range(0, 1) != 0) ? CMD_RD : CMD_WR, 8'($urandom), 8'h00});
                exp_err[1] = 1'b1;
            end
            idle(3);
            compare_all("rnd");
        end
        check("rnd_tx_stable", stab_err, 0);
        ready_mode = 0;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
